// File: rtl/target_pkg.sv
// Shared types and constants for the target-number generator.
package target_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGen,
    StReady
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam logic [15:0] LFSR_MASK  = 16'hB400;
  localparam bcd_t        DIGIT_MAX  = 4'd9;
  localparam int unsigned MAX_DIGITS = 3;

  // Galois right-shift step: the bit shifted out selects whether the taps are applied.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ LFSR_MASK;
    return r;
  endfunction

endpackage

// File: rtl/target_generator_lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed would lock up, so it is replaced by 16'h0001.
module lfsr16
  import target_pkg::*;
#(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [3:0] nibble_o
);

  localparam logic [15:0] SeedEff = (Seed == 16'h0000) ? 16'h0001 : Seed;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d   = lfsr_step(lfsr_q);
  assign nibble_o = lfsr_q[3:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SeedEff;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/target_generator.sv
// BCD target generator: draws 1-3 digits from an LFSR by rejection sampling.
// Optional TARGET_UNIQUE_EN forbids repeated digits within one target.
module target_generator
  import target_pkg::*;
#(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int unsigned RETRY_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_round,
  input  logic [1:0] max_digits,
  output logic [3:0] target_digit_1,
  output logic [3:0] target_digit_2,
  output logic [3:0] target_digit_3,
  output logic       target_valid,
  output logic       busy
);

  localparam int unsigned RetryW = ($clog2(RETRY_LIMIT + 1) > 0) ? $clog2(RETRY_LIMIT + 1) : 1;

  state_e            state_q;
  bcd_t              digit_q [MAX_DIGITS];
  logic [1:0]        idx_q;
  logic [1:0]        ndig_q;
  logic [RetryW-1:0] retry_q;
  logic              valid_q;
  logic              busy_q;

  bcd_t cand;
  bcd_t fallback;
  bcd_t value;
  logic lead_nz;
  logic forced;
  logic dup;
  logic accept;
  logic last;

  lfsr16 #(
    .Seed(SEED)
  ) u_lfsr (
    .clk_i   (clk),
    .rst_ni  (rst),
    .nibble_o(cand)
  );

  // A multi-digit target may not start with 0.
  assign lead_nz = (idx_q == 2'd0) && (ndig_q >= 2'd2);
  assign forced  = (retry_q >= RetryW'(RETRY_LIMIT));
  assign last    = (idx_q == (ndig_q - 2'd1));

`ifdef TARGET_UNIQUE_EN
  logic [15:0] used;
`endif

  always_comb begin
    dup      = 1'b0;
    fallback = (cand > DIGIT_MAX) ? (cand - 4'd10) : cand;
    if (lead_nz && (fallback == 4'd0)) fallback = 4'd1;
`ifdef TARGET_UNIQUE_EN
    used = '0;
    for (int k = 0; k < int'(MAX_DIGITS); k++) begin
      if (k < int'(idx_q)) used[digit_q[k]] = 1'b1;
    end
    dup      = used[cand];
    fallback = 4'd0;
    // Descending scan leaves the smallest eligible unused digit.
    for (int v = 9; v >= 0; v--) begin
      if (!used[v] && !(lead_nz && (v == 0))) fallback = 4'(v);
    end
`endif
    accept = 1'b0;
    value  = cand;
    if ((cand <= DIGIT_MAX) && !(lead_nz && (cand == 4'd0)) && !dup) begin
      accept = 1'b1;
    end else if (forced) begin
      accept = 1'b1;
      value  = fallback;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      digit_q <= '{default: '0};
      idx_q   <= 2'd0;
      ndig_q  <= 2'd1;
      retry_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (new_round) begin
      // Any state restarts; a partial target in progress is discarded.
      state_q <= StGen;
      digit_q <= '{default: '0};
      idx_q   <= 2'd0;
      ndig_q  <= (max_digits == 2'd0) ? 2'd1 : max_digits;
      retry_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StGen: begin
          if (accept) begin
            for (int k = 0; k < int'(MAX_DIGITS); k++) begin
              if (k == int'(idx_q)) digit_q[k] <= value;
            end
            retry_q <= '0;
            if (last) begin
              state_q <= StReady;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end else begin
            retry_q <= retry_q + RetryW'(1);
          end
        end
        StIdle, StReady: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign target_digit_1 = digit_q[0];
  assign target_digit_2 = digit_q[1];
  assign target_digit_3 = digit_q[2];
  assign target_valid   = valid_q;
  assign busy           = busy_q;

endmodule
